comparator_iter: RTL and testbench

COMPARATOR_ITER -- requirements
Module: comparator_iter

---
 rtl/comparator_iter.sv | 124 ++++++++++++
 tb/tb_comparator_iter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/comparator_iter.sv
// Iterative magnitude comparator: walks the operands K bits per cycle, MSB-first, and stops at the
// first differing chunk. Signed mode flips the sign bit so that two's-complement order matches unsigned order.
module comparator_iter #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  input  logic [2:0]   op,
  output logic         busy,
  output logic         done,
  output logic         result,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  localparam int C  = N / K;
  localparam int IW = (C > 1) ? $clog2(C) : 1;
  localparam logic [IW-1:0] LAST = IW'(C - 1);

  generate
    if ((K < 1) || (K > N) || (N % K != 0)) begin : g_bad_width
      $error("comparator_iter: N must be a positive multiple of K");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_q, b_q;
  logic [2:0]    op_q;
  logic [IW-1:0] idx;
  logic [K-1:0]  ca, cb;
  logic          c_lt, c_gt;

  // Operands shift left after each equal chunk, so the live chunk is always the top K bits.
  assign ca   = a_q[N-1 -: K];
  assign cb   = b_q[N-1 -: K];
  assign c_lt = (ca < cb);
  assign c_gt = (ca > cb);

  function automatic logic apply_op(input logic [2:0] o, input logic l, input logic e, input logic g);
    case (o)
      3'b000:  apply_op = e;
      3'b001:  apply_op = !e;
      3'b010:  apply_op = l;
      3'b011:  apply_op = l | e;
      3'b100:  apply_op = g;
      3'b101:  apply_op = g | e;
      default: apply_op = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 1'b0;
      lt     <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Flipping the sign bit at capture is the chunk-0 MSB inversion done once.
            a_q         <= a;
            a_q[N-1]    <= a[N-1] ^ is_signed;
            b_q         <= b;
            b_q[N-1]    <= b[N-1] ^ is_signed;
            op_q        <= op;
            idx         <= '0;
            busy        <= 1'b1;
            result      <= 1'b0;
            lt          <= 1'b0;
            eq          <= 1'b0;
            gt          <= 1'b0;
            state       <= COMPARE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        COMPARE: begin
          if (c_lt || c_gt) begin
            lt     <= c_lt;
            gt     <= c_gt;
            result <= apply_op(op_q, c_lt, 1'b0, c_gt);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (idx == LAST) begin
            eq     <= 1'b1;
            result <= apply_op(op_q, 1'b0, 1'b1, 1'b0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
            a_q <= a_q << K;
            b_q <= b_q << K;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_iter.sv
// Directed bench for comparator_iter (N=32, K=8): latency, relation flags, op decode, start
// handling while busy and during DONE, and asynchronous reset abort.
module tb_comparator_iter;

  localparam logic [2:0] OP_EQ = 3'b000, OP_NE = 3'b001, OP_LT = 3'b010,
                         OP_LE = 3'b011, OP_GT = 3'b100, OP_GE = 3'b101, OP_RSV = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        is_signed = 1'b0;
  logic [2:0]  op = '0;
  logic        busy, done, result, lt, eq, gt;

  int errors = 0;
  int checks = 0;

  comparator_iter #(.N(32), .K(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .is_signed(is_signed), .op(op),
    .busy(busy), .done(done), .result(result), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns just after the accepting edge.
  task automatic go(input logic [31:0] av, input logic [31:0] bv, input logic s, input logic [2:0] o);
    a = av; b = bv; is_signed = s; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges since the accepting edge (c0 already elapsed) until done; returns in the done cycle.
  task automatic wait_done(input string tag, input int c0, input int lat,
                           input logic elt, input logic eeq, input logic egt, input logic eres);
    int cnt = c0;
    check({tag, ".busy"}, {31'b0, busy}, 32'd1);
    check({tag, ".clr"}, {29'b0, lt, eq, gt}, 32'd0);
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!done && cnt < 20);
    check({tag, ".lat"}, cnt, lat);
    check({tag, ".done"}, {31'b0, done}, 32'd1);
    check({tag, ".nbusy"}, {31'b0, busy}, 32'd0);
    check({tag, ".rel"}, {29'b0, lt, eq, gt}, {29'b0, elt, eeq, egt});
    check({tag, ".res"}, {31'b0, result}, {31'b0, eres});
  endtask

  task automatic after_done(input string tag, input logic elt, input logic eeq, input logic egt, input logic eres);
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'b0, done}, 32'd0);
    check({tag, ".hold"}, {28'b0, lt, eq, gt, result}, {28'b0, elt, eeq, egt, eres});
  endtask

  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {26'b0, busy, done, result, lt, eq, gt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outs", {26'b0, busy, done, result, lt, eq, gt}, 32'd0);

    go(32'd5, 32'd7, 1'b0, OP_LT);
    wait_done("u5lt7", 0, 4, 1, 0, 0, 1);
    after_done("u5lt7", 1, 0, 0, 1);

    go(32'h8000_0000, 32'd1, 1'b1, OP_LT);
    wait_done("s_min_lt1", 0, 1, 1, 0, 0, 1);
    go(32'h8000_0000, 32'd1, 1'b0, OP_LT);
    wait_done("u_min_lt1", 0, 1, 0, 0, 1, 0);

    go(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, OP_EQ);
    wait_done("eq_eq", 0, 4, 0, 1, 0, 1);
    go(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, OP_LE);
    wait_done("eq_le", 0, 4, 0, 1, 0, 1);
    go(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, OP_GE);
    wait_done("eq_ge", 0, 4, 0, 1, 0, 1);
    go(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, OP_NE);
    wait_done("eq_ne", 0, 4, 0, 1, 0, 0);
    go(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, OP_RSV);
    wait_done("eq_rsv", 0, 4, 0, 1, 0, 0);

    // Difference in chunk 1 only; then two negatives differing in the last chunk.
    go(32'h0001_0000, 32'h0000_0000, 1'b0, OP_GT);
    wait_done("chunk1_gt", 0, 2, 0, 0, 1, 1);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, OP_GE);
    wait_done("neg_ge", 0, 4, 0, 0, 1, 1);
    go(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, OP_LE);
    wait_done("pos_le_neg", 0, 1, 0, 0, 1, 0);

    // Second start while busy must be ignored.
    go(32'd1, 32'd2, 1'b0, OP_LT);
    a = 32'd9; b = 32'd0; op = OP_GT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore", 1, 4, 1, 0, 0, 1);

    // Start during DONE chains comparisons with no idle gap.
    go(32'h1200_0000, 32'h1100_0000, 1'b0, OP_GT);
    wait_done("b2b_0", 0, 1, 0, 0, 1, 1);
    go(32'h0000_0003, 32'h0000_0003, 1'b0, OP_NE);
    wait_done("b2b_1", 0, 4, 0, 1, 0, 0);
    go(32'h0000_0100, 32'h0000_0200, 1'b0, OP_LT);
    wait_done("b2b_2", 0, 3, 1, 0, 0, 1);
    after_done("b2b_2", 1, 0, 0, 1);

    // Asynchronous reset two cycles into a comparison.
    go(32'hCAFE_0000, 32'hCAFE_0000, 1'b0, OP_EQ);
    @(posedge clk); #1;
    check("abort.busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort.outs", {26'b0, busy, done, result, lt, eq, gt}, 32'd0);
    #1 rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort.nodone", pulses, 0);
    check("abort.idle", {31'b0, busy}, 32'd0);

    go(32'd5, 32'd7, 1'b0, OP_GE);
    wait_done("post_rst", 0, 4, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
